// File: rtl/display_scan_ctrl.sv
// Scan controller for an 8-digit multiplexed 7-segment display.
// Double-buffered digit store with frame-aligned shadow->active swaps and inter-digit blanking.
module display_scan_ctrl #(
  parameter int unsigned SCAN_DIV     = 27000,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic       commit,
  output logic       commit_pending,
  output logic       frame_done,
  output logic [6:0] displayout,
  output logic [7:0] selector
);

  localparam int unsigned     CNT_W     = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_e;

  state_e           state;
  logic             boundary;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [4:0]       shadow_q [8];
  logic [4:0]       shadow_d [8];
  logic [4:0]       active_q [8];
  logic [4:0]       active_d [8];
  logic             pend_q, pend_d;
  logic             fd_q, fd_d;
  logic [7:0]       sel_q, sel_d;
  logic [6:0]       seg_q, seg_d;

  function automatic logic [6:0] hex_to_seg(input logic [4:0] d);
    logic [6:0] s;
    if (d[4]) begin
      s = 7'h7F;
    end else begin
      case (d[3:0])
        4'h0: s = 7'h40;
        4'h1: s = 7'h79;
        4'h2: s = 7'h24;
        4'h3: s = 7'h30;
        4'h4: s = 7'h19;
        4'h5: s = 7'h12;
        4'h6: s = 7'h02;
        4'h7: s = 7'h78;
        4'h8: s = 7'h00;
        4'h9: s = 7'h10;
        4'hA: s = 7'h08;
        4'hB: s = 7'h03;
        4'hC: s = 7'h46;
        4'hD: s = 7'h21;
        4'hE: s = 7'h06;
        default: s = 7'h0E;
      endcase
    end
    return s;
  endfunction

  always_comb begin
    state    = (cnt_q < BLANK_END) ? ST_BLANK : ST_SHOW;
    boundary = (idx_q == 3'd7) && (cnt_q == CNT_MAX);

    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    idx_d = (cnt_q == CNT_MAX) ? idx_q + 3'd1 : idx_q;

    shadow_d = shadow_q;
    if (wr_en) shadow_d[wr_addr] = wr_data;

    // Swap copies the pre-edge shadow, so a write on the swap edge waits for the next commit.
    active_d = active_q;
    pend_d   = pend_q;
    if (boundary && (pend_q || commit)) begin
      active_d = shadow_q;
      pend_d   = 1'b0;
    end else if (commit) begin
      pend_d = 1'b1;
    end

    fd_d  = boundary;
    sel_d = '1;
    seg_d = '1;
    if (state == ST_SHOW) begin
      sel_d = ~(8'b1 << idx_q);
      seg_d = hex_to_seg(active_q[idx_q]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        shadow_q[i] <= 5'h10;
        active_q[i] <= 5'h10;
      end
      pend_q <= 1'b0;
      fd_q   <= 1'b0;
      sel_q  <= '1;
      seg_q  <= '1;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      fd_q     <= fd_d;
      sel_q    <= sel_d;
      seg_q    <= seg_d;
    end
  end

  assign commit_pending = pend_q;
  assign frame_done     = fd_q;
  assign displayout     = seg_q;
  assign selector       = sel_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: expected digit slots are queued per frame
// from a bench-side buffer model and compared as each slot finishes on the pins.
module tb_display_scan_ctrl;

  localparam int SCAN_DIV = 10;
  localparam int BLANK    = 2;
  localparam int FRAME    = 8 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [4:0] wr_data = '0;
  logic       commit = 1'b0;
  logic       commit_pending;
  logic       frame_done;
  logic [6:0] displayout;
  logic [7:0] selector;

  display_scan_ctrl #(
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .commit        (commit),
    .commit_pending(commit_pending),
    .frame_done    (frame_done),
    .displayout    (displayout),
    .selector      (selector)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] sel;
    logic [6:0] seg;
  } slot_t;

  slot_t      sb_q[$];
  int         n_chk = 0;
  int         n_err = 0;
  int         c = 0;
  logic       pend = 1'b0;
  logic [4:0] exp_shadow [8];
  logic [4:0] exp_active [8];
  logic       mon_en = 1'b0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, c);
    end
  endtask

  function automatic logic [6:0] seg7(input logic [4:0] v);
    if (v[4]) return 7'h7F;
    case (v[3:0])
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic push_frame();
    slot_t      s;
    logic [7:0] one;
    for (int i = 0; i < 8; i++) begin
      one   = 8'd1;
      s.sel = ~(one << i);
      s.seg = seg7(exp_active[i]);
      sb_q.push_back(s);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      exp_shadow[i] = 5'h10;
      exp_active[i] = 5'h10;
    end
    pend = 1'b0;
    c    = 0;
  endtask

  // One clock: apply the edge to the model, then check per-cycle flags.
  task automatic step();
    logic       we, cm;
    logic [2:0] wa;
    logic [4:0] wd;
    we = wr_en; cm = commit; wa = wr_addr; wd = wr_data;
    @(posedge clk);
    #1;
    if ((c % FRAME) == FRAME - 1 && (pend || cm)) begin
      exp_active = exp_shadow;
      pend = 1'b0;
    end else if (cm) begin
      pend = 1'b1;
    end
    if (we) exp_shadow[wa] = wd;
    wr_en  = 1'b0;
    commit = 1'b0;
    c++;
    if ((c % FRAME) == 0) push_frame();
    check("commit_pending", int'(commit_pending), int'(pend));
    check("frame_done", int'(frame_done), ((c % FRAME) == 0) ? 1 : 0);
  endtask

  task automatic run_to(input int target);
    while (c < target) step();
  endtask

  task automatic write(input int a, input logic [4:0] d);
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_data = d;
    step();
  endtask

  // Slot monitor: measures each asserted-selector run and pops its expected record.
  logic       in_show = 1'b0;
  logic       seen_show = 1'b0;
  logic       steady = 1'b1;
  int         blank_len = 0;
  int         show_len = 0;
  logic [7:0] cur_sel = '1;
  logic [6:0] cur_seg = '1;

  always @(negedge clk) begin
    slot_t e;
    if (!mon_en) begin
      in_show   = 1'b0;
      seen_show = 1'b0;
      blank_len = 0;
    end else if (selector != 8'hFF) begin
      if (!in_show) begin
        if (seen_show) check("blank_len", blank_len, BLANK);
        in_show  = 1'b1;
        cur_sel  = selector;
        cur_seg  = displayout;
        show_len = 0;
        steady   = 1'b1;
      end
      show_len++;
      if (selector != cur_sel || displayout != cur_seg) steady = 1'b0;
    end else begin
      if (in_show) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("slot_sel", int'(cur_sel), int'(e.sel));
          check("slot_seg", int'(cur_seg), int'(e.seg));
        end
        check("slot_len", show_len, SCAN_DIV - BLANK);
        check("slot_steady", int'(steady), 1);
        in_show   = 1'b0;
        seen_show = 1'b1;
        blank_len = 0;
      end
      blank_len++;
      check("blank_seg", int'(displayout), 'h7F);
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel", int'(selector), 'hFF);
    check("rst_seg", int'(displayout), 'h7F);
    check("rst_pend", int'(commit_pending), 0);
    check("rst_fd", int'(frame_done), 0);
    rst_n = 1'b1;
    model_reset();
    push_frame();
    mon_en = 1'b1;

    run_to(80);
    for (int i = 0; i < 8; i++) write(i, 5'(i));
    run_to(120);
    commit = 1'b1;
    step();
    run_to(240);

    write(3, 5'h0A);
    run_to(500);
    write(0, 5'h0F);
    run_to(FRAME * 7 - 1);
    wr_en   = 1'b1;
    wr_addr = 3'd5;
    wr_data = 5'h0E;
    commit  = 1'b1;
    step();
    run_to(600);
    write(2, 5'h1F);
    commit = 1'b1;
    step();
    run_to(670);
    commit = 1'b1;
    step();
    run_to(685);

    check("pre_rst_sel", int'(selector), 'hEF);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sel", int'(selector), 'hFF);
    check("mid_rst_seg", int'(displayout), 'h7F);
    check("mid_rst_pend", int'(commit_pending), 0);
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    push_frame();
    mon_en = 1'b1;
    run_to(5);
    commit = 1'b1;
    step();
    run_to(165);
    check("sb_left", sb_q.size(), 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
